// File: rtl/z80_bus_bridge_if.sv
// Signal bundle between a Z80-style CPU, the bus bridge and its memory / I/O targets.
// The bridge uses the slave view; a CPU model or bench drives through the master view.
interface z80_bus_bridge_if;
    // CPU side
    logic        M1;
    logic        MREQ;
    logic        IORQ;
    logic        RD;
    logic        WR;
    logic        RFSH;
    logic [15:0] A;
    logic [7:0]  DO;
    logic [7:0]  DI;
    logic        WAIT;

    // Memory request/acknowledge port
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [15:0] MEM_ADDR;
    logic [7:0]  MEM_WDATA;
    logic [7:0]  MEM_RDATA;
    logic        MEM_ACK;

    // I/O request/acknowledge port
    logic        IO_REQ;
    logic        IO_WE;
    logic [7:0]  IO_ADDR;
    logic [7:0]  IO_WDATA;
    logic [7:0]  IO_RDATA;
    logic        IO_ACK;

    // Interrupts and status
    logic        IRQ;
    logic [7:0]  IRQ_VECTOR;
    logic        INT;
    logic        INTA;
    logic        BUS_ERR;

    modport slave (
        input  M1, MREQ, IORQ, RD, WR, RFSH, A, DO,
        output DI, WAIT,
        output MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
        input  MEM_RDATA, MEM_ACK,
        output IO_REQ, IO_WE, IO_ADDR, IO_WDATA,
        input  IO_RDATA, IO_ACK,
        input  IRQ, IRQ_VECTOR,
        output INT, INTA, BUS_ERR
    );

    modport master (
        output M1, MREQ, IORQ, RD, WR, RFSH, A, DO,
        input  DI, WAIT,
        input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
        output MEM_RDATA, MEM_ACK,
        input  IO_REQ, IO_WE, IO_ADDR, IO_WDATA,
        output IO_RDATA, IO_ACK,
        output IRQ, IRQ_VECTOR,
        input  INT, INTA, BUS_ERR
    );
endinterface

// File: rtl/z80_bus_bridge.sv
// Z80 bus bridge: turns CPU strobes into request/acknowledge cycles on a memory
// port and an I/O port, stalls the CPU with WAIT, and handles IM2 interrupt acknowledge.
module z80_bus_bridge #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input logic             CLK,
    input logic             nRESET,
    z80_bus_bridge_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        IO_WAIT  = 2'd2,
        HOLD     = 2'd3
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [7:0]  r_di;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [15:0] r_mem_addr;
    logic [7:0]  r_mem_wdata;
    logic        r_io_req;
    logic        r_io_we;
    logic [7:0]  r_io_addr;
    logic [7:0]  r_io_wdata;
    logic        r_irq_s1;
    logic        r_int;
    logic        r_inta;
    logic        r_bus_err;

    logic        w_intack;
    logic        w_mem_start;
    logic        w_io_start;
    logic        w_timeout;
    logic        w_wait;

    assign w_intack    = bus.M1 & bus.IORQ;
    assign w_mem_start = bus.MREQ & (bus.RD | bus.WR) & ~bus.RFSH;
    assign w_io_start  = bus.IORQ & ~bus.M1 & (bus.RD | bus.WR);
    // Counter starts at 0 on entry, so the request has been up TIMEOUT cycles here.
    assign w_timeout   = (r_cnt == (TIMEOUT - 8'd1));

    // WAIT stalls the CPU in the very cycle the strobe appears; intack never stalls.
    always_comb begin
        w_wait = 1'b0;
        case (r_state)
            IDLE:     w_wait = (w_mem_start | w_io_start) & ~w_intack;
            MEM_WAIT: w_wait = 1'b1;
            IO_WAIT:  w_wait = 1'b1;
            default:  w_wait = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state     <= IDLE;
            r_cnt       <= 8'd0;
            r_di        <= 8'hFF;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 16'd0;
            r_mem_wdata <= 8'd0;
            r_io_req    <= 1'b0;
            r_io_we     <= 1'b0;
            r_io_addr   <= 8'd0;
            r_io_wdata  <= 8'd0;
            r_irq_s1    <= 1'b0;
            r_int       <= 1'b0;
            r_inta      <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_irq_s1 <= bus.IRQ;
            r_int    <= r_irq_s1;
            r_inta   <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_intack) begin
                        r_di    <= bus.IRQ_VECTOR;
                        r_inta  <= 1'b1;
                        r_state <= HOLD;
                    end else if (w_mem_start) begin
                        r_mem_addr  <= bus.A;
                        r_mem_wdata <= bus.DO;
                        r_mem_we    <= bus.WR;
                        r_mem_req   <= 1'b1;
                        r_cnt       <= 8'd0;
                        r_state     <= MEM_WAIT;
                    end else if (w_io_start) begin
                        r_io_addr  <= bus.A[7:0];
                        r_io_wdata <= bus.DO;
                        r_io_we    <= bus.WR;
                        r_io_req   <= 1'b1;
                        r_cnt      <= 8'd0;
                        r_state    <= IO_WAIT;
                    end
                end

                MEM_WAIT: begin
                    if (bus.MEM_ACK) begin
                        r_mem_req <= 1'b0;
                        if (!r_mem_we) r_di <= bus.MEM_RDATA;
                        r_state   <= HOLD;
                    end else if (w_timeout) begin
                        r_mem_req <= 1'b0;
                        if (!r_mem_we) r_di <= 8'hFF;
                        r_bus_err <= 1'b1;
                        r_state   <= HOLD;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                IO_WAIT: begin
                    if (bus.IO_ACK) begin
                        r_io_req <= 1'b0;
                        if (!r_io_we) r_di <= bus.IO_RDATA;
                        r_state  <= HOLD;
                    end else if (w_timeout) begin
                        r_io_req  <= 1'b0;
                        if (!r_io_we) r_di <= 8'hFF;
                        r_bus_err <= 1'b1;
                        r_state   <= HOLD;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                // Wait for the CPU to release its strobes so one bus cycle maps to one request.
                HOLD: begin
                    if (!bus.MREQ && !bus.IORQ) r_state <= IDLE;
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.DI        = r_di;
    assign bus.WAIT      = w_wait;
    assign bus.MEM_REQ   = r_mem_req;
    assign bus.MEM_WE    = r_mem_we;
    assign bus.MEM_ADDR  = r_mem_addr;
    assign bus.MEM_WDATA = r_mem_wdata;
    assign bus.IO_REQ    = r_io_req;
    assign bus.IO_WE     = r_io_we;
    assign bus.IO_ADDR   = r_io_addr;
    assign bus.IO_WDATA  = r_io_wdata;
    assign bus.INT       = r_int;
    assign bus.INTA      = r_inta;
    assign bus.BUS_ERR   = r_bus_err;

endmodule

// File: tb/tb_z80_bus_bridge.sv
// Directed bench for z80_bus_bridge: memory/I-O cycles, intack, refresh, timeout and reset.
module tb_z80_bus_bridge;

    logic CLK;
    logic nRESET;
    int   n_checks;
    int   n_fail;
    int   w_count;
    int   r_count;

    z80_bus_bridge_if bus ();

    z80_bus_bridge #(.TIMEOUT(8'd4)) dut (
        .CLK    (CLK),
        .nRESET (nRESET),
        .bus    (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_bus();
        bus.M1 = 0; bus.MREQ = 0; bus.IORQ = 0; bus.RD = 0; bus.WR = 0; bus.RFSH = 0;
        bus.A = 16'h0000; bus.DO = 8'h00;
        bus.MEM_ACK = 0; bus.IO_ACK = 0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clear_bus();
        bus.MEM_RDATA = 8'h00; bus.IO_RDATA = 8'h00;
        bus.IRQ = 0; bus.IRQ_VECTOR = 8'h00;
        nRESET = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_di", bus.DI, 8'hFF);
        chk("rst_mem_req", bus.MEM_REQ, 0);
        chk("rst_io_req", bus.IO_REQ, 0);
        chk("rst_mem_addr", bus.MEM_ADDR, 0);
        chk("rst_io_addr", bus.IO_ADDR, 0);
        chk("rst_flags", {bus.INT, bus.INTA, bus.BUS_ERR, bus.WAIT}, 0);
        nRESET = 1'b1;
        tick();

        // Mem read, ACK low for 3 cycles then high
        bus.A = 16'h1234; bus.MREQ = 1; bus.RD = 1; bus.MEM_RDATA = 8'hA5;
        w_count = 0;
        for (int i = 0; i < 5; i++) begin
            bus.MEM_ACK = (i == 3);
            #1;
            if (bus.WAIT) w_count++;
            if (i == 1) chk("mrd_req_up", bus.MEM_REQ, 1);
            tick();
        end
        bus.MEM_ACK = 0;
        chk("mrd_wait_cycles", w_count, 4);
        chk("mrd_addr", bus.MEM_ADDR, 16'h1234);
        chk("mrd_we", bus.MEM_WE, 0);
        chk("mrd_di", bus.DI, 8'hA5);
        chk("mrd_req_down", bus.MEM_REQ, 0);
        tick();
        chk("mrd_hold_no_req", {bus.MEM_REQ, bus.WAIT}, 0);
        clear_bus();
        tick();

        // IO write, ACK already high in the first request cycle
        bus.A = 16'hBE7F; bus.DO = 8'h3C; bus.IORQ = 1; bus.WR = 1; bus.IO_ACK = 1;
        #1;
        chk("iowr_wait_idle", bus.WAIT, 1);
        tick();
        chk("iowr_req", bus.IO_REQ, 1);
        chk("iowr_addr", bus.IO_ADDR, 8'h7F);
        chk("iowr_wdata", bus.IO_WDATA, 8'h3C);
        chk("iowr_we", bus.IO_WE, 1);
        tick();
        chk("iowr_req_1cyc", bus.IO_REQ, 0);
        chk("iowr_di_kept", bus.DI, 8'hA5);
        chk("iowr_wait_low", bus.WAIT, 0);
        clear_bus();
        tick();

        // Interrupt synchroniser and intack
        bus.IRQ = 1;
        tick();
        chk("int_lat1", bus.INT, 0);
        tick();
        chk("int_lat2", bus.INT, 1);
        bus.M1 = 1; bus.IORQ = 1; bus.IRQ_VECTOR = 8'h40;
        #1;
        chk("ack_wait_idle", bus.WAIT, 0);
        tick();
        chk("ack_inta", bus.INTA, 1);
        chk("ack_di", bus.DI, 8'h40);
        chk("ack_wait_hold", bus.WAIT, 0);
        tick();
        chk("ack_inta_1cyc", bus.INTA, 0);
        bus.IRQ = 0;
        clear_bus();
        tick();

        // Refresh causes nothing; then intack wins over a simultaneous mem read
        bus.MREQ = 1; bus.RFSH = 1; bus.RD = 1;
        #1;
        chk("rfsh_wait", bus.WAIT, 0);
        tick();
        chk("rfsh_no_req", bus.MEM_REQ, 0);
        chk("rfsh_di", bus.DI, 8'h40);
        bus.RFSH = 0; bus.M1 = 1; bus.IORQ = 1; bus.IRQ_VECTOR = 8'h77;
        tick();
        chk("prio_inta", bus.INTA, 1);
        chk("prio_no_mreq", bus.MEM_REQ, 0);
        chk("prio_di", bus.DI, 8'h77);
        clear_bus();
        tick();

        // Timeout with MEM_ACK stuck low
        bus.A = 16'h5555; bus.MREQ = 1; bus.RD = 1;
        r_count = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.MEM_REQ) r_count++;
            if (i == 3) chk("to_err_pending", bus.BUS_ERR, 0);
        end
        chk("to_req_cycles", r_count, 4);
        chk("to_di", bus.DI, 8'hFF);
        chk("to_bus_err", bus.BUS_ERR, 1);
        clear_bus();
        tick();

        // Good read afterwards; a cross-port ACK is ignored, BUS_ERR stays set
        bus.A = 16'h0100; bus.MREQ = 1; bus.RD = 1; bus.MEM_RDATA = 8'h99;
        tick();
        bus.IO_ACK = 1;
        tick();
        chk("xack_ignored", bus.MEM_REQ, 1);
        bus.IO_ACK = 0; bus.MEM_ACK = 1;
        tick();
        bus.MEM_ACK = 0;
        chk("good_req_down", bus.MEM_REQ, 0);
        chk("good_di", bus.DI, 8'h99);
        chk("good_err_sticky", bus.BUS_ERR, 1);
        clear_bus();
        tick();

        // Reset in the middle of a memory wait, then a late ACK
        bus.A = 16'h2222; bus.MREQ = 1; bus.RD = 1; bus.MEM_RDATA = 8'h11;
        tick();
        tick();
        chk("mrst_req_before", bus.MEM_REQ, 1);
        nRESET = 1'b0;
        clear_bus();
        #1;
        chk("mrst_req", bus.MEM_REQ, 0);
        chk("mrst_wait", bus.WAIT, 0);
        chk("mrst_di", bus.DI, 8'hFF);
        chk("mrst_err", bus.BUS_ERR, 0);
        tick();
        nRESET = 1'b1;
        tick();
        bus.MEM_ACK = 1;
        tick();
        chk("late_ack_req", bus.MEM_REQ, 0);
        chk("late_ack_di", bus.DI, 8'hFF);
        chk("late_ack_wait", bus.WAIT, 0);
        bus.MEM_ACK = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
